// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the branch resolve unit.
// Holds the branch opcode, instruction field positions, the branch
// condition encoding, the resolve FSM states and the flag bit indices.
package cpu_isa_pkg;

    // Instruction field layout
    localparam logic [4:0]  BR_OP   = 5'b11100;
    localparam int unsigned OPC_HI  = 31;
    localparam int unsigned OPC_LO  = 27;
    localparam int unsigned COND_HI = 26;
    localparam int unsigned COND_LO = 25;
    localparam int unsigned OFF_W   = 25;

    // Flag bit positions inside the {C,N,Z} vector
    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_Z = 0;

    // Width of the flush down-counter, enough for FLUSH_CYCLES up to 7
    localparam int unsigned FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        COND_AL = 2'b00,
        COND_Z  = 2'b01,
        COND_N  = 2'b10,
        COND_C  = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StIssue = 2'b01,
        StFlush = 2'b10
    } bru_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for branch statistics.
// Ports:
//   clk   - clock, counts on posedge
//   rst   - synchronous active-high reset, clears the count
//   inc   - increment request for this cycle
//   count - current value; holds at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates fetched instructions, raises a one-cycle
// branch request towards the PC for each taken branch, squashes wrong-path
// instructions while the branch lands, keeps the {C,N,Z} flags and counts
// evaluated/taken branches.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   instr        - fetched instruction word
//   instr_valid  - instr is meaningful this cycle
//   flag_wr      - ALU writes flags this cycle
//   flags_in     - {C,N,Z} from the ALU
//   isBranch     - one-cycle PC branch request
//   jump_value   - signed word offset for the PC, zero when isBranch is low
//   squash       - decode must discard the current instruction
//   flags_q      - architectural {C,N,Z}
//   branch_cnt   - branches evaluated (saturating)
//   taken_cnt    - branches taken (saturating)
module branch_resolve_unit
    import cpu_isa_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    input  logic             flag_wr,
    input  logic [2:0]       flags_in,
    output logic             isBranch,
    output logic [OFF_W-1:0] jump_value,
    output logic             squash,
    output logic [2:0]       flags_q,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    bru_state_e             state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [OFF_W-1:0]       off_q, off_d;
    logic [2:0]             eff_flags;
    logic                   is_branch;
    logic                   cond_true;
    logic                   branch_inc;
    logic                   taken_inc;
    cond_e                  cond;

    assign is_branch = instr_valid && (instr[OPC_HI:OPC_LO] == BR_OP);
    assign cond      = cond_e'(instr[COND_HI:COND_LO]);

    // Flags written this cycle are visible to a branch in the same cycle.
    assign eff_flags = flag_wr ? flags_in : flags_q;

    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            COND_AL: cond_true = 1'b1;
            COND_Z:  cond_true = eff_flags[FLG_Z];
            COND_N:  cond_true = eff_flags[FLG_N];
            COND_C:  cond_true = eff_flags[FLG_C];
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        off_d       = off_q;
        branch_inc  = 1'b0;
        taken_inc   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (is_branch) begin
                    branch_inc = 1'b1;
                    if (cond_true) begin
                        taken_inc = 1'b1;
                        off_d     = instr[OFF_W-1:0];
                        state_d   = StIssue;
                    end
                end
            end
            StIssue: begin
                if (FLUSH_CYCLES > 0) begin
                    state_d     = StFlush;
                    flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES);
                end else begin
                    state_d = StRun;
                end
            end
            StFlush: begin
                // Counter holds the FLUSH cycles still to go, including this one.
                flush_cnt_d = flush_cnt_q - 1'b1;
                if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
            off_q       <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            off_q       <= off_d;
            if (flag_wr) begin
                flags_q <= flags_in;
            end
        end
    end

    always_comb begin
        isBranch   = (state_q == StIssue);
        jump_value = isBranch ? off_q : '0;
        squash     = (state_q != StRun);
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (branch_inc),
        .count (branch_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (taken_inc),
        .count (taken_cnt)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a vector table against the default
// configuration, plus sequences on a FLUSH_CYCLES=3 and a CNT_W=4 instance.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        flag_wr;
    logic [2:0]  flags_in;

    logic        ib_a, sq_a;
    logic [24:0] jv_a;
    logic [2:0]  fl_a;
    logic [15:0] bc_a, tc_a;

    logic        ib_b, sq_b;
    logic [24:0] jv_b;
    logic [2:0]  fl_b;
    logic [15:0] bc_b, tc_b;

    logic        ib_c, sq_c;
    logic [24:0] jv_c;
    logic [2:0]  fl_c;
    logic [3:0]  bc_c, tc_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut_a (
        .clk (clk), .rst (rst), .instr (instr), .instr_valid (instr_valid),
        .flag_wr (flag_wr), .flags_in (flags_in), .isBranch (ib_a), .jump_value (jv_a),
        .squash (sq_a), .flags_q (fl_a), .branch_cnt (bc_a), .taken_cnt (tc_a)
    );

    branch_resolve_unit #(.FLUSH_CYCLES(3)) dut_b (
        .clk (clk), .rst (rst), .instr (instr), .instr_valid (instr_valid),
        .flag_wr (flag_wr), .flags_in (flags_in), .isBranch (ib_b), .jump_value (jv_b),
        .squash (sq_b), .flags_q (fl_b), .branch_cnt (bc_b), .taken_cnt (tc_b)
    );

    branch_resolve_unit #(.CNT_W(4)) dut_c (
        .clk (clk), .rst (rst), .instr (instr), .instr_valid (instr_valid),
        .flag_wr (flag_wr), .flags_in (flags_in), .isBranch (ib_c), .jump_value (jv_c),
        .squash (sq_c), .flags_q (fl_c), .branch_cnt (bc_c), .taken_cnt (tc_c)
    );

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        valid;
        logic        fwr;
        logic [2:0]  fin;
        logic        ib;
        logic [24:0] jv;
        logic        sq;
        logic [2:0]  fl;
        logic [15:0] bc;
        logic [15:0] tc;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    function automatic logic [31:0] br(input logic [1:0] c, input logic [24:0] off);
        return {5'b11100, c, off};
    endfunction

    function automatic vec_t mk(input logic r, input logic [31:0] i, input logic v,
                                input logic fw, input logic [2:0] fi, input logic ib,
                                input logic [24:0] jv, input logic sq, input logic [2:0] fl,
                                input logic [15:0] bc, input logic [15:0] tc);
        vec_t x;
        x.rst = r; x.instr = i; x.valid = v; x.fwr = fw; x.fin = fi;
        x.ib = ib; x.jv = jv; x.sq = sq; x.fl = fl; x.bc = bc; x.tc = tc;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic [31:0] i, input logic v,
                        input logic fw, input logic [2:0] fi);
        @(negedge clk);
        rst = r; instr = i; instr_valid = v; flag_wr = fw; flags_in = fi;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_sq_b[5];
        logic exp_ib_b[5];
        rst = 1'b1; instr = '0; instr_valid = 1'b0; flag_wr = 1'b0; flags_in = '0;

        //              rst  instr                   v  fwr fin     ib jv            sq fl      bc  tc
        vecs[0]  = mk(1, 32'h0,                  0, 0, 3'b000, 0, 25'h0,       0, 3'b000, 0, 0);
        vecs[1]  = mk(0, br(2'b00, 25'h10),      1, 0, 3'b000, 1, 25'h10,      1, 3'b000, 1, 1);
        vecs[2]  = mk(0, 32'h0,                  0, 0, 3'b000, 0, 25'h0,       1, 3'b000, 1, 1);
        vecs[3]  = mk(0, 32'h0,                  0, 0, 3'b000, 0, 25'h0,       0, 3'b000, 1, 1);
        vecs[4]  = mk(0, br(2'b01, 25'h1FFFFFC), 1, 0, 3'b000, 0, 25'h0,       0, 3'b000, 2, 1);
        vecs[5]  = mk(0, br(2'b01, 25'h1FFFFFC), 1, 1, 3'b001, 1, 25'h1FFFFFC, 1, 3'b001, 3, 2);
        vecs[6]  = mk(0, br(2'b00, 25'h44),      1, 0, 3'b000, 0, 25'h0,       1, 3'b001, 3, 2);
        vecs[7]  = mk(0, br(2'b00, 25'h44),      1, 0, 3'b000, 0, 25'h0,       0, 3'b001, 3, 2);
        vecs[8]  = mk(0, 32'h0,                  1, 1, 3'b010, 0, 25'h0,       0, 3'b010, 3, 2);
        vecs[9]  = mk(0, br(2'b10, 25'h5),       1, 0, 3'b000, 1, 25'h5,       1, 3'b010, 4, 3);
        vecs[10] = mk(1, 32'h0,                  0, 0, 3'b000, 0, 25'h0,       0, 3'b000, 0, 0);
        vecs[11] = mk(0, br(2'b11, 25'h7),       1, 1, 3'b100, 1, 25'h7,       1, 3'b100, 1, 1);
        vecs[12] = mk(0, br(2'b00, 25'h9),       1, 1, 3'b000, 0, 25'h0,       1, 3'b000, 1, 1);
        vecs[13] = mk(0, br(2'b11, 25'h3),       1, 0, 3'b000, 0, 25'h0,       0, 3'b000, 1, 1);
        vecs[14] = mk(0, br(2'b11, 25'h3),       1, 0, 3'b000, 0, 25'h0,       0, 3'b000, 2, 1);
        vecs[15] = mk(0, br(2'b00, 25'h3),       0, 0, 3'b000, 0, 25'h0,       0, 3'b000, 2, 1);
        vecs[16] = mk(0, {5'b11101, 27'h0000003}, 1, 0, 3'b000, 0, 25'h0,      0, 3'b000, 2, 1);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].instr, vecs[i].valid, vecs[i].fwr, vecs[i].fin);
            chk($sformatf("v%0d isBranch", i), 32'(ib_a), 32'(vecs[i].ib));
            chk($sformatf("v%0d jump_value", i), 32'(jv_a), 32'(vecs[i].jv));
            chk($sformatf("v%0d squash", i), 32'(sq_a), 32'(vecs[i].sq));
            chk($sformatf("v%0d flags_q", i), 32'(fl_a), 32'(vecs[i].fl));
            chk($sformatf("v%0d branch_cnt", i), 32'(bc_a), 32'(vecs[i].bc));
            chk($sformatf("v%0d taken_cnt", i), 32'(tc_a), 32'(vecs[i].tc));
        end

        // FLUSH_CYCLES=3: squash for ISSUE plus three FLUSH cycles, one pulse.
        exp_sq_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_ib_b = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        step(1, 32'h0, 0, 0, 3'b000);
        chk("f3 reset squash", 32'(sq_b), 32'd0);
        step(0, br(2'b00, 25'h20), 1, 0, 3'b000);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("f3 c%0d squash", i), 32'(sq_b), 32'(exp_sq_b[i]));
            chk($sformatf("f3 c%0d isBranch", i), 32'(ib_b), 32'(exp_ib_b[i]));
            // Keep offering taken branches; only the one in RUN may be accepted.
            step(0, br(2'b00, 25'h21), (i < 3) ? 1'b1 : 1'b0, 0, 3'b000);
        end
        chk("f3 branch_cnt", 32'(bc_b), 32'd1);
        chk("f3 taken_cnt", 32'(tc_b), 32'd1);

        // CNT_W=4: 17 taken branches each followed by two non-branches.
        step(1, 32'h0, 0, 0, 3'b000);
        for (int i = 1; i <= 17; i++) begin
            step(0, br(2'b00, 25'h1), 1, 0, 3'b000);
            step(0, 32'h0, 1, 0, 3'b000);
            step(0, 32'h0, 1, 0, 3'b000);
            if (i == 1 || i == 15) begin
                chk($sformatf("sat b%0d branch_cnt", i), 32'(bc_c), (i == 1) ? 32'd1 : 32'hF);
                chk($sformatf("sat b%0d taken_cnt", i), 32'(tc_c), (i == 1) ? 32'd1 : 32'hF);
            end
        end
        chk("sat final branch_cnt", 32'(bc_c), 32'hF);
        chk("sat final taken_cnt", 32'(tc_c), 32'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
